uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer between the UART receiver and the RISC-V bus interface. Captures each word the receiver reports with its one-cycle `data_ready` strobe into a circular buffer. The processor side drains words in first-word-fall-through order. Absorbs bursts while firmware is busy, so no received byte is lost unless the buffer is full.

## Interface
Parameters:
- `DBITS`, 8, width of one data word (matches receiver word width)
- `ADDR_WIDTH`, 4, log2 of buffer depth; depth = 2**ADDR_WIDTH (16 default)

Ports:
- `clk_100MHz`  input  1  system clock; all logic on rising edge
- `reset_n`  input  1  reset; one clock; reset is synchronous and active-low
- `wr_strobe`  input  1  one-cycle pulse from receiver, word complete
- `wr_data`  input  DBITS  received word, valid when `wr_strobe`=1
- `rd_en`  input  1  pop head word at this edge (bus side)
- `rd_data`  output  DBITS  head word; valid whenever `empty`=0
- `empty`  output  1  no words stored
- `full`  output  1  2**ADDR_WIDTH words stored
- `count`  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH
- `overflow`  output  1  sticky dropped-word flag (only with `UART_RX_FIFO_OVF_EN`)
- `ovf_clr`  input  1  clears `overflow` (only with `UART_RX_FIFO_OVF_EN`)

## Operation
- Write and read pointers are ADDR_WIDTH+1 bits. Low ADDR_WIDTH bits index storage; MSB is the wrap bit.
- `empty` = pointers equal. `full` = index bits equal, wrap bits differ. `count` = wr_ptr − rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Write accepted when `wr_strobe`=1 and (`full`=0 or `rd_en`=1). Stores `wr_data` at wr_ptr index, then wr_ptr+1.
- Read accepted when `rd_en`=1 and `empty`=0. Advances rd_ptr by 1. `rd_data` then shows the next word.
- `rd_data` is a combinational read of storage at the rd_ptr index. Its value while `empty`=1 is don't-care; it is not forced to 0.
- Boundary cases:
  - Pointers wrap naturally through 2**ADDR_WIDTH−1 → 0. Wrap bit toggles on each wrap.
  - `rd_en` while empty: ignored, no pointer change.
  - `wr_strobe` while full and `rd_en`=0: word dropped, no pointer change.
  - Simultaneous write+read, not empty: both occur, `count` unchanged.
  - Simultaneous write+read while full: read pops head, write stores into the freed slot, `count` stays 2**ADDR_WIDTH.
  - Simultaneous write+read while empty: only the write occurs. New word visible on `rd_data` next cycle.
- Reset mid-operation discards all contents. Storage array is not reset; only pointers and flags are.

## Timing
- Reset values: `empty`=1, `full`=0, `count`=0, `overflow`=0, pointers 0. `rd_data` is don't-care.
- Write-to-visible latency: 1 cycle. Word strobed at edge N appears on `rd_data` with `empty`=0 after edge N.
- Pop latency: 1 cycle. `rd_data`, `count`, `empty`, `full` update after the accepting edge.
- Status outputs derive from registered pointers only. There is no combinational path from `wr_strobe`/`rd_en` to any output.
- Back-to-back `rd_en` every cycle is legal. `wr_strobe` arrives at most once per character time, but the design accepts one per cycle.

## Configuration
- `UART_RX_FIFO_OVF_EN` defined:
  - `overflow` and `ovf_clr` ports exist.
  - `overflow` is set at the edge where a write is dropped and held until `ovf_clr`=1.
  - Set has priority over clear in the same cycle.
- Not defined: both ports absent, dropped writes are silent, no extra flops.

## Structure
- Package `uart_pkg`: default `DBITS` and `ADDR_WIDTH` constants, shared with receiver and bus interface.
- Sub-module `uart_rx_fifo_mem`: DBITS × 2**ADDR_WIDTH array with one synchronous write port and one asynchronous read port. Maps to distributed RAM.
- Pointer, flag and overflow logic stay in the top module.

## Test plan
- Reset: hold `reset_n`=0 two cycles, release → `empty`=1, `full`=0, `count`=0, `overflow`=0.
- Single word: strobe 0xA5, then `rd_en` next cycle → `rd_data`=0xA5, `count` 1→0, `empty` returns to 1.
- Fill and wrap: write 0x00..0x0F → `full`=1, `count`=16. Pop 8, write 0x10..0x17, pop all 16 → order 0x08..0x17.
- Overflow (macro on): fill 16, strobe 0xEE → word dropped, `overflow`=1. Pop → head is 0x00, not 0xEE. Pulse `ovf_clr` → `overflow`=0.
- Simultaneous while full: write 0x55 with `rd_en`=1 → head pops, `count` stays 16, 0x55 emerges 16th.
- Empty corner and reset mid-operation:
  - `rd_en`+`wr_strobe` 0x3C on empty → `count`=1, `rd_data`=0x3C.
  - Then load 5 words and assert `reset_n`=0 → `count`=0, `empty`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART word/buffer sizing for receiver, rx buffer and bus interface.
// Latency: n/a (constants only). Backpressure: n/a.
// Constants only; no logic.
package uart_pkg;
    localparam int UART_DBITS      = 8;
    localparam int UART_ADDR_WIDTH = 4;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Rx buffer storage: one synchronous write port, one asynchronous read port.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none, the caller decides when a write is legal.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DBITS      = UART_DBITS,
    parameter int ADDR_WIDTH = UART_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DBITS-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DBITS-1:0]      rdata_o
);

    // Deliberately unreset so the array maps onto distributed RAM.
    logic [DBITS-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FWFT buffer; optional sticky overflow flag via UART_RX_FIFO_OVF_EN.
// Latency: strobed word visible on rd_data one cycle later; pops take effect after the edge.
// Backpressure: none upstream; a strobe while full (without rd_en) drops the word.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBITS      = UART_DBITS,
    parameter int ADDR_WIDTH = UART_ADDR_WIDTH
) (
    input  logic                  clk_100MHz,
    input  logic                  reset_n,
    input  logic                  wr_strobe,
    input  logic [DBITS-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [DBITS-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
`ifdef UART_RX_FIFO_OVF_EN
    ,
    output logic                  overflow,
    input  logic                  ovf_clr
`endif
);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                wr_acc;
    logic                rd_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A write into a full buffer is fine when the same edge pops the head.
    assign wr_acc = wr_strobe && (!full || rd_en);
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef UART_RX_FIFO_OVF_EN
    logic overflow_q, overflow_d;

    // Set wins over clear so a drop coinciding with ovf_clr is never lost.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_strobe && full && !rd_en) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

    uart_rx_fifo_mem #(
        .DBITS      (DBITS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i   (clk_100MHz),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    logic       clk_100MHz = 1'b0;
    logic       reset_n    = 1'b0;
    logic       wr_strobe  = 1'b0;
    logic [7:0] wr_data    = 8'h00;
    logic       rd_en      = 1'b0;
    logic       ovf_clr    = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
`ifdef UART_RX_FIFO_OVF_EN
    logic       overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_rx_fifo #(.DBITS(8), .ADDR_WIDTH(4)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .wr_strobe  (wr_strobe),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count)
`ifdef UART_RX_FIFO_OVF_EN
        ,
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
`endif
    );

    // Drives one cycle from a negedge, advances the model, returns at the next negedge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit was_full;
        was_full  = (mq.size() == 16);
        wr_strobe = w;
        wr_data   = d;
        rd_en     = r;
        ovf_clr   = c;
        if (!reset_n) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (r && mq.size() > 0) void'(mq.pop_front());
            if (w && (!was_full || r)) mq.push_back(d);
            if (w && was_full && !r) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        wr_strobe = 1'b0;
        rd_en     = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
`ifdef UART_RX_FIFO_OVF_EN
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
`endif
    endtask

    task automatic test_single();
        do_reset();
        step(1, 8'hA5, 0, 0);
        n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h exp a5", rd_data); end
        n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count1 got %0d exp 1", count); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_nempty got %b exp 0", empty); end
        step(0, 8'h00, 1, 0);
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL single_count0 got %0d exp 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got %b exp 1", empty); end
        step(0, 8'h00, 1, 0);
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL rd_on_empty got %0d exp 0", count); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", full); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count got %0d exp 16", count); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL fill_pop got %h exp %h", rd_data, 8'(i)); end
            step(0, 8'h00, 1, 0);
        end
        for (int i = 16; i < 24; i++) step(1, 8'(i), 0, 0);
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL wrap_count got %0d exp 16", count); end
        for (int i = 8; i < 24; i++) begin
            n_checks++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL wrap_order got %h exp %h", rd_data, 8'(i)); end
            step(0, 8'h00, 1, 0);
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b exp 1", empty); end
    endtask

`ifdef UART_RX_FIFO_OVF_EN
    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        step(1, 8'hEE, 0, 0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d exp 16", count); end
        step(1, 8'hEF, 0, 1);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_prio got %b exp 1", overflow); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL ovf_head got %h exp 00", rd_data); end
        step(0, 8'h00, 1, 0);
        n_checks++; if (rd_data !== 8'h01) begin n_fail++; $display("FAIL ovf_next got %h exp 01", rd_data); end
        step(0, 8'h00, 0, 1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    endtask
`endif

    task automatic test_simul_full();
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        step(1, 8'h55, 1, 0);
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL simfull_count got %0d exp 16", count); end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL simfull_full got %b exp 1", full); end
        for (int i = 1; i < 17; i++) begin
            n_checks++;
            if (rd_data !== ((i == 16) ? 8'h55 : 8'(i))) begin
                n_fail++; $display("FAIL simfull_order idx %0d got %h", i, rd_data);
            end
            step(0, 8'h00, 1, 0);
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL simfull_empty got %b exp 1", empty); end
    endtask

    task automatic test_empty_corner_reset();
        do_reset();
        step(1, 8'h3C, 1, 0);
        n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL ecorner_count got %0d exp 1", count); end
        n_checks++; if (rd_data !== 8'h3C) begin n_fail++; $display("FAIL ecorner_data got %h exp 3c", rd_data); end
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
        n_checks++; if (count !== 5'd6) begin n_fail++; $display("FAIL midrst_pre got %0d exp 6", count); end
        reset_n = 1'b0;
        step(1, 8'h99, 1, 0);
        reset_n = 1'b1;
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL midrst_count got %0d exp 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got %b exp 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL midrst_full got %b exp 0", full); end
    endtask

    task automatic test_random();
        int rd_bias;
        do_reset();
        for (int cyc = 0; cyc < 1200; cyc++) begin
            rd_bias = ((cyc / 100) % 2 == 0) ? 20 : 75;
            step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < rd_bias),
                 1'($urandom_range(0, 9) == 0));
            n_checks++; if (count !== 5'(mq.size())) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, count, mq.size()); end
            n_checks++; if (empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rnd_empty cyc %0d got %b", cyc, empty); end
            n_checks++; if (full !== (mq.size() == 16)) begin n_fail++; $display("FAIL rnd_full cyc %0d got %b", cyc, full); end
            if (mq.size() > 0) begin
                n_checks++; if (rd_data !== mq[0]) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, rd_data, mq[0]); end
            end
`ifdef UART_RX_FIFO_OVF_EN
            n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", cyc, overflow, m_ovf); end
`endif
        end
    endtask

    initial begin
        @(negedge clk_100MHz);
        test_reset();
        test_single();
        test_fill_wrap();
`ifdef UART_RX_FIFO_OVF_EN
        test_overflow();
`endif
        test_simul_full();
        test_empty_corner_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
